// File: rtl/bus_target.sv
// bus_target: responder end of the 4-phase byte bus, bridging bus phases to a valid/ready backend
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   bus_handshake_req/ack      4-phase handshake (req from initiator, ack from target)
//   bus_state, bus_io          phase code (00 addr lo, 01 addr hi, 10 read, 11 write), I/O qualifier
//   bus_data_in                byte driven by the initiator
//   bus_data_out, bus_output_enable  read byte and its driver enable
//   mem_valid/write/io/addr/wdata    backend request
//   mem_rdata, mem_ready       backend response
//   proto_err                  one-cycle pulse on a phase-order violation
module bus_target #(
    parameter int SYNC_STAGES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_handshake_req,
    output logic        bus_handshake_ack,
    input  logic [1:0]  bus_state,
    input  logic        bus_io,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        bus_output_enable,
    output logic        mem_valid,
    output logic        mem_write,
    output logic        mem_io,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        proto_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MEM   = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;
    logic [1:0] state;
    logic [1:0] seq;
    logic [7:0] addr_hi;
    logic [7:0] addr_lo;
    logic [SYNC_STAGES:0] sync;
    logic req_s;
    // sync[0] is the raw request; each stage adds one flop of delay
    assign sync[0] = bus_handshake_req;
    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        always_ff @(posedge clk) begin
            sync[g+1] <= rst_n ? sync[g] : 1'b0;
        end
    end
    assign req_s    = sync[SYNC_STAGES];
    assign mem_addr = {addr_hi, addr_lo};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            seq               <= 2'd0;
            addr_hi           <= 8'h00;
            addr_lo           <= 8'h00;
            bus_handshake_ack <= 1'b0;
            bus_output_enable <= 1'b0;
            bus_data_out      <= 8'h00;
            mem_valid         <= 1'b0;
            mem_write         <= 1'b0;
            mem_io            <= 1'b0;
            mem_wdata         <= 8'h00;
            proto_err         <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_s) begin
                        if (!bus_state[1]) begin
                            bus_handshake_ack <= 1'b1;
                            state             <= ACK;
                            if (!bus_state[0]) begin
                                addr_lo <= bus_data_in;
                                seq     <= 2'd1;
                            end else begin
                                addr_hi   <= bus_data_in;
                                seq       <= 2'd2;
                                proto_err <= (seq != 2'd1);
                            end
                        end else begin
                            // out-of-order data phase is flagged but still executed
                            mem_valid <= 1'b1;
                            mem_write <= bus_state[0];
                            mem_io    <= bus_io;
                            proto_err <= (seq != 2'd2);
                            state     <= MEM;
                            if (bus_state[0])
                                mem_wdata <= bus_data_in;
                        end
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        seq       <= 2'd0;
                        if (mem_write) begin
                            bus_handshake_ack <= 1'b1;
                            state             <= ACK;
                        end else begin
                            bus_data_out      <= mem_rdata;
                            bus_output_enable <= 1'b1;
                            state             <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    // one cycle of settled read data before ack
                    bus_handshake_ack <= 1'b1;
                    state             <= ACK;
                end
                default: begin
                    // driver released with ack so it is off before the initiator re-drives
                    if (!req_s) begin
                        bus_handshake_ack <= 1'b0;
                        bus_output_enable <= 1'b0;
                        state             <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_target.sv
// tb_bus_target: directed self-checking bench for bus_target
module tb_bus_target;
    logic        clk = 1'b0;
    logic        rst_n, req, req2, bio, ready;
    logic [1:0]  bstate;
    logic [7:0]  din, rdata;
    logic        ack, oe, mvalid, mwrite, mio, perr;
    logic [7:0]  dout, mwdata;
    logic [15:0] maddr;
    logic        ack2, oe2, mvalid2, mwrite2, mio2, perr2;
    logic [7:0]  dout2, mwdata2;
    logic [15:0] maddr2;
    logic        init_oe = 1'b0;
    int          checks = 0, failures = 0;
    int          pe_cnt = 0, clash = 0, oe_bad = 0;
    logic [7:0]  got;

    always #5 clk = ~clk;

    bus_target #(.SYNC_STAGES(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus_handshake_req(req), .bus_handshake_ack(ack),
        .bus_state(bstate), .bus_io(bio), .bus_data_in(din), .bus_data_out(dout),
        .bus_output_enable(oe), .mem_valid(mvalid), .mem_write(mwrite), .mem_io(mio),
        .mem_addr(maddr), .mem_wdata(mwdata), .mem_rdata(rdata), .mem_ready(ready),
        .proto_err(perr)
    );

    bus_target #(.SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus_handshake_req(req2), .bus_handshake_ack(ack2),
        .bus_state(bstate), .bus_io(bio), .bus_data_in(din), .bus_data_out(dout2),
        .bus_output_enable(oe2), .mem_valid(mvalid2), .mem_write(mwrite2), .mem_io(mio2),
        .mem_addr(maddr2), .mem_wdata(mwdata2), .mem_rdata(rdata), .mem_ready(1'b0),
        .proto_err(perr2)
    );

    always @(negedge clk) begin
        if (perr) pe_cnt++;
        if (init_oe && oe) clash++;
        if (oe && bstate != 2'b10) oe_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [1:0] st, input logic [7:0] d, input logic pe);
        bstate = st; din = d; init_oe = 1'b1; req = 1'b1;
        tick;
        chk("addr_ack", ack, 1);
        chk("addr_perr", perr, pe);
        req = 1'b0; init_oe = 1'b0;
        tick;
        chk("addr_release", ack, 0);
        chk("addr_perr_clear", perr, 0);
    endtask

    task automatic data_phase(input logic wr, input logic io_v, input logic [7:0] d, input int w,
                              input logic [7:0] rd_v, input logic [15:0] a, input logic pe,
                              output logic [7:0] rd);
        bstate = {1'b1, wr}; bio = io_v; din = d; init_oe = wr; req = 1'b1;
        tick;
        chk("mv_start", mvalid, 1);
        chk("mwrite", mwrite, wr);
        chk("mio", mio, io_v);
        chk("maddr", maddr, a);
        chk("data_perr", perr, pe);
        if (wr) chk("mwdata", mwdata, d);
        for (int i = 0; i < w; i++) begin
            tick;
            chk("mv_hold", mvalid, 1);
            chk("ack_wait", ack, 0);
            chk("maddr_hold", maddr, a);
        end
        ready = 1'b1; rdata = rd_v;
        tick;
        ready = 1'b0; rdata = 8'h00;
        chk("mv_drop", mvalid, 0);
        if (wr) begin
            chk("wr_ack", ack, 1);
            chk("wr_oe", oe, 0);
            chk("wr_mwdata", mwdata, d);
        end else begin
            chk("rd_ack_early", ack, 0);
            chk("rd_oe", oe, 1);
            chk("rd_data", dout, rd_v);
            tick;
            chk("rd_ack", ack, 1);
            chk("rd_oe_hold", oe, 1);
        end
        rd = dout;
        req = 1'b0; init_oe = 1'b0;
        tick;
        chk("rel_ack", ack, 0);
        chk("rel_oe", oe, 0);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; req2 = 1'b0; bio = 1'b0; ready = 1'b0;
        bstate = 2'b00; din = 8'h00; rdata = 8'h00;
        tick; tick;
        chk("rst_ack", ack, 0);
        chk("rst_oe", oe, 0);
        chk("rst_mv", mvalid, 0);
        chk("rst_mwrite", mwrite, 0);
        chk("rst_mio", mio, 0);
        chk("rst_perr", perr, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_mwdata", mwdata, 8'h00);
        chk("rst_maddr", maddr, 16'h0000);
        chk("rst_ack2", ack2, 0);
        rst_n = 1'b1;
        tick;
        ready = 1'b1;
        tick;
        ready = 1'b0;
        chk("idle_ready_mv", mvalid, 0);
        chk("idle_ready_ack", ack, 0);

        // read 0x1234 -> 0xA5, no wait
        addr_phase(2'b00, 8'h34, 1'b0);
        addr_phase(2'b01, 8'h12, 1'b0);
        chk("rd_addr", maddr, 16'h1234);
        data_phase(1'b0, 1'b0, 8'h00, 0, 8'hA5, 16'h1234, 1'b0, got);
        chk("rd_latched", got, 8'hA5);
        chk("rd_no_perr", pe_cnt, 0);

        // write 0x5A to I/O 0xBEEF with 3 wait cycles
        addr_phase(2'b00, 8'hEF, 1'b0);
        addr_phase(2'b01, 8'hBE, 1'b0);
        data_phase(1'b1, 1'b1, 8'h5A, 3, 8'h00, 16'hBEEF, 1'b0, got);
        chk("wr_no_perr", pe_cnt, 0);

        // address-high with no address-low first
        addr_phase(2'b01, 8'h99, 1'b1);
        chk("perr_once", pe_cnt, 1);
        addr_phase(2'b00, 8'h11, 1'b0);
        addr_phase(2'b01, 8'h22, 1'b0);
        data_phase(1'b0, 1'b0, 8'h00, 1, 8'h3C, 16'h2211, 1'b0, got);
        chk("recover_rd", got, 8'h3C);
        chk("perr_total", pe_cnt, 1);

        // reset while driving read data
        addr_phase(2'b00, 8'h01, 1'b0);
        addr_phase(2'b01, 8'h02, 1'b0);
        bstate = 2'b10; req = 1'b1;
        tick;
        chk("rr_mv", mvalid, 1);
        ready = 1'b1; rdata = 8'hC3;
        tick;
        ready = 1'b0; rdata = 8'h00;
        chk("rr_drive_oe", oe, 1);
        rst_n = 1'b0;
        tick;
        chk("rr_ack", ack, 0);
        chk("rr_oe", oe, 0);
        chk("rr_mv_after", mvalid, 0);
        chk("rr_dout", dout, 8'h00);
        rst_n = 1'b1; req = 1'b0;
        tick;
        addr_phase(2'b00, 8'h56, 1'b0);
        addr_phase(2'b01, 8'h78, 1'b0);
        data_phase(1'b0, 1'b0, 8'h00, 2, 8'h69, 16'h7856, 1'b0, got);
        chk("rr_next_rd", got, 8'h69);

        // two-stage synchronizer: ack follows req by 3 edges each way
        bstate = 2'b00; din = 8'h77; req2 = 1'b1;
        tick; chk("s2_ack_e0", ack2, 0);
        tick; chk("s2_ack_e1", ack2, 0);
        tick; chk("s2_ack_e2", ack2, 1);
        chk("s2_addr_lo", maddr2[7:0], 8'h77);
        req2 = 1'b0;
        tick; chk("s2_rel_e0", ack2, 1);
        tick; chk("s2_rel_e1", ack2, 1);
        tick; chk("s2_rel_e2", ack2, 0);

        // back-to-back read then write, zero initiator turnaround
        addr_phase(2'b00, 8'hCD, 1'b0);
        addr_phase(2'b01, 8'hAB, 1'b0);
        data_phase(1'b0, 1'b0, 8'h00, 0, 8'h81, 16'hABCD, 1'b0, got);
        chk("b2b_rd", got, 8'h81);
        addr_phase(2'b00, 8'h10, 1'b0);
        addr_phase(2'b01, 8'h20, 1'b0);
        data_phase(1'b1, 1'b0, 8'hC7, 0, 8'h00, 16'h2010, 1'b0, got);
        chk("b2b_mwdata", mwdata, 8'hC7);
        chk("no_clash", clash, 0);
        chk("oe_only_read", oe_bad, 0);
        chk("final_perr", pe_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
